// File: rtl/one_hot_codec_pkg.sv
// Shared types for the one-hot encoder/decoder.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
// Contents: codec_mode_e selects encode or decode. codec_item_t is one buffered result.
package one_hot_codec_pkg;

  typedef enum logic {
    ENCODE = 1'b0,
    DECODE = 1'b1
  } codec_mode_e;

  // A package cannot be parametrised, so the item struct carries a data field
  // wide enough for any supported OUTPUT_WIDTH. Users slice the low bits they need.
  localparam int unsigned CODEC_MAX_W = 64;

  typedef struct packed {
    logic                   err;
    logic [CODEC_MAX_W-1:0] data;
  } codec_item_t;

endpackage

// File: rtl/one_hot_codec_if.sv
// Valid/ready bus for the one-hot codec: the input item channel, the result channel and the error count.
// Latency: none (wiring only).
// Backpressure: in_ready and out_ready carry the flow control of each channel.
// The slave modport is the codec's view. The master modport is the producer/consumer view.
interface one_hot_codec_if #(
  parameter int INPUT_WIDTH   = 3,
  parameter int OUTPUT_WIDTH  = 1 << INPUT_WIDTH,
  parameter int ERR_CNT_WIDTH = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_mode;
  logic [OUTPUT_WIDTH-1:0]  in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUTPUT_WIDTH-1:0]  out_data;
  logic                     out_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, err_count
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, err_count
  );

endinterface

// File: rtl/one_hot_codec_skid.sv
// Two-entry valid/ready buffer: an output register backed by one skid register.
// Latency: 1 cycle from accept to out_valid when the output is empty or draining.
// Backpressure: in_ready is a flop equal to !skid_full. It never depends combinationally on out_ready.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready/in_data; out_valid/out_ready/out_data.
module one_hot_codec_skid #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_rdy_q, in_rdy_d;

  logic accept;
  logic drain;

  assign accept = in_valid && in_rdy_q;
  assign drain  = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    if (skid_vld_q) begin
      // in_ready is low while the skid register is full, so no accept can
      // happen here. A drain promotes the skid entry into the output register.
      if (drain) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end
    end else if (!out_vld_q || drain) begin
      // The output register is free this cycle, so a new item loads it directly.
      out_vld_d = accept;
      if (accept) begin
        out_dat_d = in_data;
      end
    end else if (accept) begin
      // The output is stalled. Park the item in the skid register.
      skid_vld_d = 1'b1;
      skid_dat_d = in_data;
    end

    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      in_rdy_q   <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;

endmodule

// File: rtl/one_hot_codec.sv
// Per-item one-hot codec: ENCODE turns a binary index into one-hot; DECODE turns one-hot into a binary index and flags bad input.
// Latency: 1 cycle (combinational codec feeding a 2-entry skid buffer).
// Backpressure: absorbs one extra item while the output is stalled, then drops in_ready.
// Ports: clk, rst_n (sync, active-low); bus (slave) carries both valid/ready channels and err_count.
module one_hot_codec
  import one_hot_codec_pkg::*;
#(
  parameter int INPUT_WIDTH   = 3,
  parameter int OUTPUT_WIDTH  = 1 << INPUT_WIDTH,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  one_hot_codec_if.slave   bus
);

  localparam int PAY_W = OUTPUT_WIDTH + 1;

  codec_mode_e              mode;
  codec_item_t              item_d;
  logic [INPUT_WIDTH-1:0]   low_idx;
  logic                     accept;
  logic [PAY_W-1:0]         skid_out;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     unused_data_hi;

  assign mode = codec_mode_e'(bus.in_mode);

  // Scan from the top down so that the last hit is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = OUTPUT_WIDTH - 1; i >= 0; i--) begin
      if (bus.in_data[i]) begin
        low_idx = INPUT_WIDTH'(i);
      end
    end
  end

  always_comb begin
    item_d = '0;
    if (mode == ENCODE) begin
      item_d.data = CODEC_MAX_W'(1) << bus.in_data[INPUT_WIDTH-1:0];
    end else begin
      // Zero set bits leave low_idx at 0, which is the required result.
      item_d.data = CODEC_MAX_W'(low_idx);
      item_d.err  = ($countones(bus.in_data) != 1);
    end
  end

  // The bits of the struct above OUTPUT_WIDTH are always zero and are never buffered.
  assign unused_data_hi = |(item_d.data >> OUTPUT_WIDTH);

  one_hot_codec_skid #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({item_d.err, item_d.data[OUTPUT_WIDTH-1:0]}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (skid_out)
  );

  assign bus.out_err  = skid_out[PAY_W-1];
  assign bus.out_data = skid_out[OUTPUT_WIDTH-1:0];

  // Errors are counted when the item is accepted, not when it drains.
  // The counter saturates at all-ones.
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && (mode == DECODE) && item_d.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_one_hot_codec.sv
// Directed bench for one_hot_codec (INPUT_WIDTH = 3). u_dut uses a 16-bit error counter and u_dut2 uses a 2-bit one.
// Vectors carry hand-computed results. Outputs are sampled 1 ns after the rising edge.
module tb_one_hot_codec;
  import one_hot_codec_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  one_hot_codec_if #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(8), .ERR_CNT_WIDTH(16)) bus  ();
  one_hot_codec_if #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(8), .ERR_CNT_WIDTH(2))  bus2 ();

  one_hot_codec #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(8), .ERR_CNT_WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  one_hot_codec #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(8), .ERR_CNT_WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streaming vectors for u_dut with out_ready held high.
  logic        v_mode [0:8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]  v_din  [0:8] = '{8'h05, 8'hF9, 8'h08, 8'h00, 8'h44, 8'h07, 8'h00, 8'h80, 8'h01};
  logic [7:0]  v_dout [0:8] = '{8'h20, 8'h02, 8'h03, 8'h00, 8'h02, 8'h80, 8'h01, 8'h07, 8'h00};
  logic        v_err  [0:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] v_cnt  [0:8] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};

  // DECODE vectors for u_dut2. Every item after the first is erroneous, so the 2-bit counter saturates at 3.
  logic [7:0] w_din  [0:5] = '{8'h10, 8'h00, 8'h03, 8'h60, 8'hFF, 8'h81};
  logic [7:0] w_dout [0:5] = '{8'h04, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
  logic       w_err  [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] w_cnt  [0:5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_mode    = ENCODE;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_mode   = DECODE;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check_eq("rst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst out_data",  32'(bus.out_data),  32'd0);
    check_eq("rst out_err",   32'(bus.out_err),   32'd0);
    check_eq("rst err_count", 32'(bus.err_count), 32'd0);
    check_eq("rst in_ready",  32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post-rst in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("post-rst out_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back mixed ENCODE/DECODE stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = v_mode[i];
      bus.in_data  = v_din[i];
      step();
      check_eq($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check_eq($sformatf("vec%0d out_data", i),  32'(bus.out_data),  32'(v_dout[i]));
      check_eq($sformatf("vec%0d out_err", i),   32'(bus.out_err),   32'(v_err[i]));
      check_eq($sformatf("vec%0d err_count", i), 32'(bus.err_count), 32'(v_cnt[i]));
    end
    bus.in_valid = 1'b0;
    step();
    check_eq("idle out_valid", 32'(bus.out_valid), 32'd0);

    // Stall: items 1 and 2 are accepted, item 3 is held upstream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = ENCODE;
    bus.in_data   = 8'h01;
    step();
    check_eq("stall1 out_data", 32'(bus.out_data), 32'h02);
    check_eq("stall1 in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_data = 8'h02;
    step();
    check_eq("stall2 in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("stall2 out_data", 32'(bus.out_data), 32'h02);
    bus.in_data = 8'h03;
    step();
    check_eq("stall3 in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("stall3 out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("stall3 out_data",  32'(bus.out_data),  32'h02);
    bus.out_ready = 1'b1;
    step();
    check_eq("drain1 out_data", 32'(bus.out_data), 32'h04);
    check_eq("drain1 in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_eq("drain2 out_data",  32'(bus.out_data),  32'h08);
    check_eq("drain2 out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check_eq("drain3 out_valid", 32'(bus.out_valid), 32'd0);

    // Reset while both entries are full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = DECODE;
    bus.in_data   = 8'h00;
    step();
    check_eq("fill err_count", 32'(bus.err_count), 32'd3);
    bus.in_mode = ENCODE;
    bus.in_data = 8'h05;
    step();
    check_eq("fill in_ready", 32'(bus.in_ready), 32'd0);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_eq("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst out_data",  32'(bus.out_data),  32'd0);
    check_eq("midrst err_count", 32'(bus.err_count), 32'd0);
    check_eq("midrst in_ready",  32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    step();
    check_eq("midrst+1 in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("midrst+1 out_valid", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("midrst+2 out_valid", 32'(bus.out_valid), 32'd0);

    // Saturating 2-bit error counter
    for (int i = 0; i < 6; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = w_din[i];
      step();
      check_eq($sformatf("sat%0d out_data", i),  32'(bus2.out_data),  32'(w_dout[i]));
      check_eq($sformatf("sat%0d out_err", i),   32'(bus2.out_err),   32'(w_err[i]));
      check_eq($sformatf("sat%0d err_count", i), 32'(bus2.err_count), 32'(w_cnt[i]));
    end
    bus2.in_valid = 1'b0;
    step();
    check_eq("sat idle err_count", 32'(bus2.err_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/one_hot_codec.md
ONE_HOT_CODEC -- requirements
Module: one_hot_codec

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 3, binary code width (>=1).
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 1 << INPUT_WIDTH, one-hot code width.
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 16, width of the saturating error counter.
REQ-004 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: in_valid  input  1  upstream item valid.
REQ-007 SHALL have port: in_ready  output  1  block can accept an item.
REQ-008 SHALL have port: in_mode  input  1  0 = ENCODE (binary to one-hot), 1 = DECODE (one-hot to binary).
REQ-009 SHALL have port: in_data  input  OUTPUT_WIDTH  operand; ENCODE uses bits [INPUT_WIDTH-1:0] only.
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port: out_data  output  OUTPUT_WIDTH  result; DECODE result zero-extended from INPUT_WIDTH.
REQ-013 SHALL have port: out_err  output  1  result came from a DECODE input that was not exactly one-hot.
REQ-014 SHALL have port: err_count  output  ERR_CNT_WIDTH  number of accepted erroneous DECODE items.

Function
REQ-015 Transfer SHALL occur on in_valid && in_ready (input side) and on out_valid && out_ready (output side).
REQ-016 ENCODE SHALL produce out_data with exactly bit in_data[INPUT_WIDTH-1:0] set and out_err = 0.
REQ-017 DECODE SHALL produce the index of the lowest set bit of in_data.
REQ-018 DECODE with zero bits set SHALL produce out_data = 0 and out_err = 1.
REQ-019 DECODE with more than one bit set SHALL produce the lowest-set-bit index and out_err = 1.
REQ-020 Latency SHALL be 1 cycle: an item accepted in cycle N SHALL be presented with out_valid = 1 in cycle N+1 when the output is empty or draining.
REQ-021 Buffering SHALL be 2 entries: an output register plus a skid register.
REQ-022 in_ready SHALL be driven from a register and SHALL equal !skid_full; it SHALL NOT combinationally depend on out_ready.
REQ-023 With the output stalled (out_valid && !out_ready), one further item SHALL be accepted into the skid register, after which in_ready SHALL be 0.
REQ-024 When the output drains, the skid entry SHALL move to the output register in that cycle, and in_ready SHALL return to 1 the following cycle.
REQ-025 Items SHALL leave in acceptance order, with no loss or duplication.
REQ-026 out_data and out_err SHALL be held stable while out_valid && !out_ready.
REQ-027 Simultaneous accept and drain with skid empty SHALL load the new item directly into the output register, keeping out_valid = 1.
REQ-028 err_count SHALL increment by 1 when an erroneous DECODE item is accepted at the input, not when it is drained.
REQ-029 err_count SHALL saturate at 2^ERR_CNT_WIDTH-1 and SHALL NOT wrap.
REQ-030 in_mode SHALL be captured per item; mixed ENCODE and DECODE streams SHALL be supported back-to-back.

Reset
REQ-031 While rst_n = 0 at a rising clk edge, the following SHALL apply: out_valid = 0, out_data = 0, out_err = 0, err_count = 0, skid cleared, in_ready = 0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n is sampled high.
REQ-033 Reset mid-operation SHALL discard all buffered items without emitting them.

Structure
REQ-034 Package one_hot_codec_pkg SHALL hold typedef enum logic codec_mode_e {ENCODE, DECODE}.
REQ-035 Package one_hot_codec_pkg SHALL hold a packed struct type for the buffered item, containing data and err fields.
REQ-036 The 2-entry valid/ready buffer SHALL be a sub-module named one_hot_codec_skid, parametrised by payload width.
REQ-037 The encode/decode logic SHALL be combinational in the top level, ahead of the skid.

Verification (INPUT_WIDTH = 3)
REQ-038 Scenario: ENCODE in_data = 8'h05 -> next cycle out_data = 8'b0010_0000, out_err = 0.
REQ-039 Scenario: ENCODE in_data = 8'hF9 -> out_data = 8'b0000_0010, confirming the upper bits are ignored.
REQ-040 Scenario: DECODE in_data = 8'h08, then 8'h00, then 8'h44 -> results are 3/err 0, 0/err 1, 2/err 1, and err_count = 2.
REQ-041 Scenario: out_ready = 0 with ENCODE items 1, 2, 3 offered -> 1 and 2 accepted, in_ready = 0 after the second accept, 3 held upstream; raising out_ready -> 8'h02, 8'h04, 8'h08 in order.
REQ-042 Scenario: ERR_CNT_WIDTH = 2 with 5 erroneous DECODE items -> err_count = 3.
REQ-043 Scenario: rst_n = 0 for one cycle while both buffer entries are full -> out_valid = 0, err_count = 0, no stale item emitted, and in_ready = 1 in the next cycle.
